// File: rtl/struct_unpacker.sv
// Byte-stream to 16-bit record unpacker: first byte (in_sof=1) is field a, second is field b.
// Define STRUCT_UNPACKER_CHKSUM_EN to require a third byte equal to a ^ b per record (drives err_chk).

module struct_unpacker #(
  parameter int unsigned IDLE_MAX = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_rec,
  output logic        err_sync,
  output logic        err_chk
);

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } rec_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GOT_A = 2'd1
`ifdef STRUCT_UNPACKER_CHKSUM_EN
    ,
    ST_GOT_B = 2'd2
`endif
  } state_e;

  localparam bit              TIMEOUT_EN = (IDLE_MAX > 0);
  localparam int unsigned     CNT_W      = (IDLE_MAX > 1) ? $clog2(IDLE_MAX) : 1;
  // Abort fires on the IDLE_MAX-th consecutive idle cycle, i.e. when the count already shows IDLE_MAX-1.
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_EN ? IDLE_MAX - 1 : 0);

  state_e           state_q, state_d;
  logic [7:0]       a_q, a_d;
  rec_t             rec_q, rec_d;
  logic             out_valid_q, out_valid_d;
  logic             err_sync_q, err_sync_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`ifdef STRUCT_UNPACKER_CHKSUM_EN
  logic [7:0]       b_q, b_d;
  logic             err_chk_q, err_chk_d;
`endif

  logic byte_acc;
  logic out_fire;
  logic complete;
  rec_t new_rec;

  // A new byte can always be taken unless a finished record is still waiting for the consumer.
  assign in_ready = !(out_valid_q && !out_ready);
  assign byte_acc = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    state_d     = state_q;
    a_d         = a_q;
    rec_d       = rec_q;
    out_valid_d = out_valid_q && !out_fire;
    err_sync_d  = 1'b0;
    idle_cnt_d  = idle_cnt_q;
    complete    = 1'b0;
    new_rec     = '{a: a_q, b: in_data};
`ifdef STRUCT_UNPACKER_CHKSUM_EN
    b_d         = b_q;
    err_chk_d   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (byte_acc) begin
          if (in_sof) begin
            a_d     = in_data;
            state_d = ST_GOT_A;
          end else begin
            err_sync_d = 1'b1;
          end
        end
      end

      ST_GOT_A: begin
        if (byte_acc) begin
          if (in_sof) begin
            err_sync_d = 1'b1;
            a_d        = in_data;
          end else begin
`ifdef STRUCT_UNPACKER_CHKSUM_EN
            b_d     = in_data;
            state_d = ST_GOT_B;
`else
            complete = 1'b1;
            state_d  = ST_IDLE;
`endif
          end
        end
      end

`ifdef STRUCT_UNPACKER_CHKSUM_EN
      ST_GOT_B: begin
        if (byte_acc) begin
          if (in_sof) begin
            err_sync_d = 1'b1;
            a_d        = in_data;
            state_d    = ST_GOT_A;
          end else if (in_data == (a_q ^ b_q)) begin
            complete = 1'b1;
            new_rec  = '{a: a_q, b: b_q};
            state_d  = ST_IDLE;
          end else begin
            err_chk_d = 1'b1;
            state_d   = ST_IDLE;
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // An accepted byte always wins over a timeout landing on the same cycle.
    if (state_q == ST_IDLE || byte_acc) begin
      idle_cnt_d = '0;
    end else if (TIMEOUT_EN) begin
      if (idle_cnt_q == CNT_LAST) begin
        idle_cnt_d = '0;
        state_d    = ST_IDLE;
        err_sync_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end

    // Completion overrides a same-cycle drain so back-to-back records leave no bubble.
    if (complete) begin
      rec_d       = new_rec;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every flop sample pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      rec_q       <= '0;
      out_valid_q <= 1'b0;
      err_sync_q  <= 1'b0;
      idle_cnt_q  <= '0;
`ifdef STRUCT_UNPACKER_CHKSUM_EN
      b_q         <= '0;
      err_chk_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      rec_q       <= rec_d;
      out_valid_q <= out_valid_d;
      err_sync_q  <= err_sync_d;
      idle_cnt_q  <= idle_cnt_d;
`ifdef STRUCT_UNPACKER_CHKSUM_EN
      b_q         <= b_d;
      err_chk_q   <= err_chk_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_rec   = rec_q;
  assign err_sync  = err_sync_q;
`ifdef STRUCT_UNPACKER_CHKSUM_EN
  assign err_chk   = err_chk_q;
`else
  assign err_chk   = 1'b0;
`endif

  // A stalled record must not change under the consumer.
  a_hold_stalled: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid_q && !out_ready) |=> (out_valid_q && $stable(rec_q)));

endmodule

// File: doc/struct_unpacker.md
STRUCT_UNPACKER -- requirements
Module: struct_unpacker

Interface
REQ-001 SHALL have parameter IDLE_MAX, default 16: max idle cycles mid-record before abort; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  byte stream valid.
REQ-005 SHALL have port in_ready  output  1  byte stream ready.
REQ-006 SHALL have port in_data  input  8  byte payload.
REQ-007 SHALL have port in_sof  input  1  marks first byte of a record (field a).
REQ-008 SHALL have port out_valid  output  1  record valid.
REQ-009 SHALL have port out_ready  input  1  record consumer ready.
REQ-010 SHALL have port out_rec  output  16  packed record {a[15:8], b[7:0]}, two-byte packed struct layout, a first.
REQ-011 SHALL have port err_sync  output  1  one-cycle framing error pulse.
REQ-012 SHALL have port err_chk  output  1  one-cycle checksum error pulse (tied 0 without macro).

Function
REQ-013 SHALL transfer a byte on in_valid && in_ready, and a record on out_valid && out_ready.
REQ-014 SHALL implement states IDLE (expect a), GOT_A (expect b), GOT_B (expect checksum, macro only).
REQ-015 SHALL drive in_ready = !(out_valid && !out_ready), combinationally.
REQ-016 IDLE: accepted byte with in_sof=1 SHALL latch a, go GOT_A; with in_sof=0 SHALL drop byte, pulse err_sync, stay IDLE.
REQ-017 GOT_A: accepted byte with in_sof=0 SHALL latch b and complete the record (no macro) or go GOT_B (macro).
REQ-018 GOT_A/GOT_B: accepted byte with in_sof=1 SHALL discard the partial record, pulse err_sync, latch new a, go GOT_A.
REQ-019 Record completion SHALL load out_rec and set out_valid on the next edge; latency from final accepted byte to out_valid = 1 cycle; state returns IDLE.
REQ-020 out_rec and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-021 Completion in the same cycle as an output handshake SHALL load the new record with out_valid remaining 1 (back-to-back, no bubble).
REQ-022 Idle counter SHALL count cycles in GOT_A/GOT_B with no accepted byte, clear on any accepted byte or on IDLE.
REQ-023 When counter reaches IDLE_MAX (IDLE_MAX>0), SHALL abort to IDLE and pulse err_sync; a byte accepted that same cycle SHALL take precedence over the abort.
REQ-024 err_sync and err_chk SHALL be registered, asserted exactly one cycle per event.

Reset
REQ-025 While rst_n=0 at a clk edge: state=IDLE, out_valid=0, out_rec=16'h0000, err_sync=0, err_chk=0, idle counter=0.
REQ-026 Reset mid-record SHALL discard the partial record and any pending output; in_ready=1 in the first cycle after reset release.

Configuration
REQ-027 Macro STRUCT_UNPACKER_CHKSUM_EN defined: each record SHALL carry a third byte (in_sof=0) equal to a ^ b; match completes the record, mismatch drops it, pulses err_chk, returns IDLE.
REQ-028 Macro undefined: records SHALL be two bytes, GOT_B and checksum logic absent, err_chk tied 0.

Verification
REQ-029 Bytes AA(sof),55, out_ready=1 -> out_valid one cycle after 55, out_rec=16'hAA55, no errors.
REQ-030 Byte 12 with sof=0 in IDLE -> dropped, err_sync pulse, no record.
REQ-031 AA(sof),BB(sof),CC -> one err_sync pulse, single record 16'hBBCC.
REQ-032 out_ready=0 after record 16'h0102, then 03(sof),04 -> in_ready=0, out_rec holds 16'h0102 until out_ready=1, then 16'h0304 follows with no bubble.
REQ-033 AA(sof), then 16 idle cycles (IDLE_MAX=16) -> err_sync pulse, state IDLE, following 55 sof=0 flags err_sync again.
REQ-034 Macro defined: 0F(sof),F0,FF -> record 16'h0FF0; 0F(sof),F0,00 -> err_chk pulse, no record.
